// File: rtl/morse_pkg.sv
// Shared Morse definitions: pattern width, default word gap, FSM state type, MSB finder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package morse_pkg;

  localparam int PAT_W                  = 20;
  localparam int IDX_W                  = $clog2(PAT_W);
  localparam int DEFAULT_WORD_GAP_UNITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Position of the highest set bit; 0 for an all-zero pattern (caller treats that as a gap).
  function automatic logic [IDX_W-1:0] msb_pos(input logic [PAT_W-1:0] p);
    logic [IDX_W-1:0] pos;
    pos = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (p[i]) pos = IDX_W'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Unit prescaler: one-cycle tick on the last clock of every Morse time unit.
// Latency: first tick UNIT_CYCLES cycles after restart while run is held.
// Backpressure: none; counter holds when run is low, restart zeroes it.
module morse_unit_tick #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  // Count 0..UNIT_CYCLES-1 while running, wrapping on the tick; restart aligns to a new unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_serializer.sv
// Plays one right-aligned Morse pattern per character on o_key, one bit per unit, MSB-first from highest set bit.
// Latency: o_key valid the cycle after accept; o_done the cycle after the last unit; back-to-back has no dead units.
// Backpressure: o_ready only in IDLE, nothing queued. Optional tone output under MORSE_SERIALIZER_TONE_EN.
module morse_serializer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES    = 4,
  parameter int WORD_GAP_UNITS = DEFAULT_WORD_GAP_UNITS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_key,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_tone
);

  // A gap reuses the bit index as a unit down-counter, so it starts at the last gap unit.
  localparam logic [IDX_W-1:0] GAP_LAST = IDX_W'(WORD_GAP_UNITS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, idx_dec;
  logic [PAT_W-1:0] pat, pat_nxt;
  logic             key, key_nxt;
  logic             done, done_nxt;
  logic             ready_en;
  logic             accept;
  logic             tick;

  // ready_en keeps o_ready low until the first clock after reset release.
  assign o_ready = ready_en && (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign o_key   = key;
  assign o_done  = done;
  assign accept  = i_valid && o_ready;
  assign idx_dec = idx - 1'b1;

  morse_unit_tick #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_tick (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .restart(accept),
    .run    (o_busy),
    .tick   (tick)
  );

  // State, pattern, index and registered key/done outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      pat      <= '0;
      key      <= 1'b0;
      done     <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      pat      <= pat_nxt;
      key      <= key_nxt;
      done     <= done_nxt;
      ready_en <= 1'b1;
    end
  end

  // Next state: load on accept, step one bit/unit per tick, finish after index 0.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pat_nxt   = pat;
    key_nxt   = key;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        key_nxt = 1'b0;
        if (accept) begin
          if (i_pattern != '0) begin
            state_nxt = SEND;
            pat_nxt   = i_pattern;
            idx_nxt   = msb_pos(i_pattern);
            key_nxt   = 1'b1;
          end else begin
            state_nxt = GAP;
            idx_nxt   = GAP_LAST;
          end
        end
      end
      SEND: begin
        if (tick) begin
          if (idx == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            key_nxt   = 1'b0;
          end else begin
            idx_nxt = idx_dec;
            key_nxt = pat[idx_dec];
          end
        end
      end
      GAP: begin
        key_nxt = 1'b0;
        if (tick) begin
          if (idx == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx_dec;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        key_nxt   = 1'b0;
      end
    endcase
  end

`ifdef MORSE_SERIALIZER_TONE_EN
  localparam int TONE_HALF_CYCLES = 2;
  localparam int TONE_W = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF_CYCLES - 1);

  logic [TONE_W-1:0] tone_cnt;
  logic              tone;

  // Square wave runs only while keyed; held preset while key is off so each key-on starts in phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tone_cnt <= '0;
      tone     <= 1'b1;
    end else if (!key) begin
      tone_cnt <= '0;
      tone     <= 1'b1;
    end else if (tone_cnt == TONE_LAST) begin
      tone_cnt <= '0;
      tone     <= ~tone;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

  assign o_tone = tone & key;
`else
  assign o_tone = 1'b0;
`endif

endmodule

// File: tb/tb_morse_serializer.sv
// Self-checking bench for morse_serializer: directed characters plus random patterns vs a waveform model.
// Latency: n/a (testbench).
// Backpressure: exercises ignored i_valid while busy and accept on the o_done cycle.
module tb_morse_serializer;

  localparam int PW = 20;
  localparam int U  = 4;
  localparam int WG = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic          ready, key, busy, done, tone;

  int n_chk  = 0;
  int n_fail = 0;

  morse_serializer #(
    .UNIT_CYCLES   (U),
    .WORD_GAP_UNITS(WG)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_pattern(pattern),
    .i_valid  (valid),
    .o_ready  (ready),
    .o_key    (key),
    .o_busy   (busy),
    .o_done   (done),
    .o_tone   (tone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Idle cycles: nothing should move.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_busy",  32'(busy),  32'd0);
      check("idle_key",   32'(key),   32'd0);
      check("idle_done",  32'(done),  32'd0);
    end
  endtask

  // Called at a negedge with the DUT idle: hands over p, then checks the whole key waveform
  // against the expected unit sequence and the o_done cycle. Returns at the o_done negedge.
  task automatic play(input logic [PW-1:0] p, input bit hold_valid, input string name);
    logic exp_q[$];
    int   msb;
    exp_q = {};
    if (p == '0) begin
      for (int i = 0; i < WG * U; i++) exp_q.push_back(1'b0);
    end else begin
      msb = 0;
      for (int b = 0; b < PW; b++) if (p[b]) msb = b;
      for (int b = msb; b >= 0; b--)
        for (int r = 0; r < U; r++) exp_q.push_back(p[b]);
    end

    check({name, "_ready_pre"}, 32'(ready), 32'd1);
    valid   = 1'b1;
    pattern = p;
    @(posedge clk);
    @(negedge clk);
    valid   = hold_valid;
    pattern = hold_valid ? 'z : PW'($urandom);

    foreach (exp_q[k]) begin
      if (k > 0) @(negedge clk);
      check($sformatf("%s_key[%0d]", name, k),   32'(key),   32'(exp_q[k]));
      check($sformatf("%s_busy[%0d]", name, k),  32'(busy),  32'd1);
      check($sformatf("%s_ready[%0d]", name, k), 32'(ready), 32'd0);
      check($sformatf("%s_done[%0d]", name, k),  32'(done),  32'd0);
`ifndef MORSE_SERIALIZER_TONE_EN
      check($sformatf("%s_tone[%0d]", name, k),  32'(tone),  32'd0);
`endif
    end

    @(negedge clk);
    check({name, "_done"},       32'(done),  32'd1);
    check({name, "_done_ready"}, 32'(ready), 32'd1);
    check({name, "_done_busy"},  32'(busy),  32'd0);
    check({name, "_done_key"},   32'(key),   32'd0);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p;

    // Reset state
    #12;
    check("rst_key",   32'(key),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_tone",  32'(tone),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready_low", 32'(ready), 32'd0);
    @(negedge clk);
    check("rel_ready_high", 32'(ready), 32'd1);

    // Directed characters
    play(20'h00008, 1'b0, "E");
    idle(2);
    play(20'h002A8, 1'b0, "H");
    play(20'hEEEE8, 1'b0, "nine");
    play(20'h00000, 1'b0, "space");
    idle(1);

    // i_valid held with z data during E is ignored; next char accepted on the done cycle
    play(20'h00008, 1'b1, "E_hold");
    play(20'h002A8, 1'b0, "after_hold");
    idle(1);

    // Reset in the middle of '9'
    valid   = 1'b1;
    pattern = 20'hEEEE8;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_key_before", 32'(key), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_key",   32'(key),   32'd0);
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_done_hold", 32'(done), 32'd0);
      check("mid_rst_key_hold",  32'(key),  32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_done",  32'(done),  32'd0);
    play(20'h00008, 1'b0, "E_after_rst");

    // Random patterns, mixing back-to-back and idle gaps
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 5) == 0) p = '0;
      else p = PW'($urandom) >> $urandom_range(0, PW - 1);
      play(p, 1'b0, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
